// File: rtl/data_inf_pkg.sv
// Shared types and helpers for the data_inf stream bridges.
package data_inf_pkg;

  typedef enum logic {
    B2A_BYPASS = 1'b0,
    B2A_FIFO   = 1'b1
  } b2a_mode_e;

  // Pointer width with one extra wrap bit above the address bits.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/data_inf_fwft_core.sv
// First-word-fall-through FIFO with generic valid/ready on both sides.
// Ready/valid/data are decoded from registered pointers only.
module data_inf_fwft_core
  import data_inf_pkg::*;
#(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DSIZE-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DSIZE-1:0]           out_data,
  input  logic                       out_ready,
  output logic [ptr_w(DEPTH)-1:0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = ptr_w(DEPTH);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign in_ready  = !full && !rst;
  assign out_valid = !empty;
  // Stale memory is never exposed, so outputs stay defined without clearing mem.
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

endmodule

// File: rtl/data_inf_b2a_fifo.sv
// Bridges a data_inf_c slaver stream onto a data_inf master stream,
// either as plain wires (MODE=0) or through an FWFT FIFO (MODE=1).
module data_inf_b2a_fifo
  import data_inf_pkg::*;
#(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned MODE  = 1
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       slaver_valid,
  input  logic [DSIZE-1:0]           slaver_data,
  output logic                       slaver_ready,
  output logic                       master_valid,
  output logic [DSIZE-1:0]           master_data,
  input  logic                       master_ready,
  output logic [ptr_w(DEPTH)-1:0]    count
);

  localparam b2a_mode_e MODE_E = (MODE != 0) ? B2A_FIFO : B2A_BYPASS;

  generate
    if (MODE_E == B2A_FIFO) begin : g_fifo
      data_inf_fwft_core #(
        .DSIZE (DSIZE),
        .DEPTH (DEPTH)
      ) u_core (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (slaver_valid),
        .in_data   (slaver_data),
        .in_ready  (slaver_ready),
        .out_valid (master_valid),
        .out_data  (master_data),
        .out_ready (master_ready),
        .count     (count)
      );
    end else begin : g_bypass
      // Legacy zero-latency wire-through; clock and rst are unused here.
      assign slaver_ready = master_ready;
      assign master_valid = slaver_valid;
      assign master_data  = slaver_data;
      assign count        = '0;
    end
  endgenerate

endmodule

// File: tb/tb_data_inf_b2a_fifo.sv
// Self-checking bench for data_inf_b2a_fifo: FIFO mode against a queue model,
// plus a bypass-mode instance.
module tb_data_inf_b2a_fifo;
  localparam int unsigned DSIZE = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic             clock = 1'b0;
  logic             rst;
  logic             slaver_valid, slaver_ready;
  logic [DSIZE-1:0] slaver_data;
  logic             master_valid, master_ready;
  logic [DSIZE-1:0] master_data;
  logic [CW-1:0]    count;

  logic             b_slaver_valid, b_slaver_ready;
  logic [DSIZE-1:0] b_slaver_data;
  logic             b_master_valid, b_master_ready;
  logic [DSIZE-1:0] b_master_data;
  logic [CW-1:0]    b_count;

  int checks = 0;
  int failures = 0;

  logic [DSIZE-1:0] q[$];
  logic [DSIZE-1:0] got[$];
  bit last_push, last_pop;

  always #5 clock = ~clock;

  data_inf_b2a_fifo #(.DSIZE(DSIZE), .DEPTH(DEPTH), .MODE(1)) dut (
    .clock(clock), .rst(rst),
    .slaver_valid(slaver_valid), .slaver_data(slaver_data), .slaver_ready(slaver_ready),
    .master_valid(master_valid), .master_data(master_data), .master_ready(master_ready),
    .count(count)
  );

  data_inf_b2a_fifo #(.DSIZE(DSIZE), .DEPTH(DEPTH), .MODE(0)) byp (
    .clock(clock), .rst(rst),
    .slaver_valid(b_slaver_valid), .slaver_data(b_slaver_data), .slaver_ready(b_slaver_ready),
    .master_valid(b_master_valid), .master_data(b_master_data), .master_ready(b_master_ready),
    .count(b_count)
  );

  // Expected {slaver_ready, master_valid, master_data, count} from queue contents.
  function automatic logic [DSIZE+CW+1:0] model_out();
    logic             rdy, vld;
    logic [DSIZE-1:0] d;
    rdy = (q.size() < DEPTH) && !rst;
    vld = (q.size() != 0);
    d   = vld ? q[0] : '0;
    return {rdy, vld, d, CW'(q.size())};
  endfunction

  // Advance one clock, applying the transfers the model predicts for this edge.
  task automatic tick();
    bit push, pop;
    push = slaver_valid && !rst && (q.size() < DEPTH);
    pop  = master_ready && !rst && (q.size() != 0);
    if (pop) got.push_back(master_data);
    @(posedge clock);
    if (rst) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(slaver_data);
    end
    last_push = push;
    last_pop  = pop;
    #1;
  endtask

  task automatic drain();
    slaver_valid = 1'b0;
    master_ready = 1'b1;
    for (int c = 0; c < 2 * DEPTH + 2 && q.size() != 0; c++) tick();
    master_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; slaver_valid = 1'b1; slaver_data = 8'h77; master_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({slaver_ready, master_valid, master_data, count} !== {1'b0, 1'b0, 8'h00, 3'd0}) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", c,
                 {slaver_ready, master_valid, master_data, count}, {1'b0, 1'b0, 8'h00, 3'd0});
      end
    end
    rst = 1'b0; slaver_valid = 1'b0;
    #1;
    checks++;
    if (slaver_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release slaver_ready got=%b exp=1", slaver_ready);
    end
  endtask

  task automatic test_fill_full();
    logic [DSIZE-1:0] words [5];
    int idx;
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    idx = 0; master_ready = 1'b0; slaver_valid = 1'b1; slaver_data = words[0];
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if ({slaver_ready, master_valid, master_data, count} !== model_out()) begin
        failures++;
        $display("FAIL fill cyc=%0d got=%h exp=%h", c,
                 {slaver_ready, master_valid, master_data, count}, model_out());
      end
      tick();
      if (last_push) begin idx++; slaver_data = words[idx]; end
    end
    checks++;
    if ({slaver_ready, count} !== {1'b0, 3'd4} || idx != 4) begin
      failures++;
      $display("FAIL full_state got rdy=%b cnt=%0d pushed=%0d exp rdy=0 cnt=4 pushed=4",
               slaver_ready, count, idx);
    end
    got.delete(); master_ready = 1'b1;
    for (int c = 0; c < 12 && got.size() < 5; c++) begin
      #1;
      checks++;
      if ({slaver_ready, master_valid, master_data, count} !== model_out()) begin
        failures++;
        $display("FAIL unload cyc=%0d got=%h exp=%h", c,
                 {slaver_ready, master_valid, master_data, count}, model_out());
      end
      tick();
      if (last_push) slaver_valid = 1'b0;
    end
    checks++;
    if (got.size() != 5 || got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33 ||
        got[3] !== 8'h44 || got[4] !== 8'h55 || count !== 3'd0) begin
      failures++;
      $display("FAIL fill_order got=%p cnt=%0d exp=11 22 33 44 55 cnt=0", got, count);
    end
    drain();
  endtask

  task automatic test_stream_wrap();
    got.delete(); master_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      slaver_valid = (i < 20);
      slaver_data  = DSIZE'(i);
      #1;
      checks++;
      if ({slaver_ready, master_valid, master_data, count} !== model_out()) begin
        failures++;
        $display("FAIL stream cyc=%0d got=%h exp=%h", i,
                 {slaver_ready, master_valid, master_data, count}, model_out());
      end
      tick();
    end
    checks++;
    if (got.size() != 20 || count !== 3'd0) begin
      failures++;
      $display("FAIL stream_count got words=%0d cnt=%0d exp words=20 cnt=0", got.size(), count);
    end
    for (int i = 0; i < 20 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== DSIZE'(i)) begin
        failures++;
        $display("FAIL stream_order idx=%0d got=%h exp=%h", i, got[i], DSIZE'(i));
      end
    end
    master_ready = 1'b0; slaver_valid = 1'b0;
  endtask

  task automatic test_full_push_pop();
    master_ready = 1'b0; slaver_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      slaver_data = 8'hA0 + DSIZE'(i);
      tick();
    end
    slaver_data = 8'hB4; master_ready = 1'b1;
    #1;
    checks++;
    if ({slaver_ready, master_valid, master_data, count} !== {1'b0, 1'b1, 8'hA0, 3'd4}) begin
      failures++;
      $display("FAIL fpp_full got=%h exp=%h",
               {slaver_ready, master_valid, master_data, count}, {1'b0, 1'b1, 8'hA0, 3'd4});
    end
    tick();
    master_ready = 1'b0;
    #1;
    checks++;
    if ({slaver_ready, master_valid, master_data, count} !== {1'b1, 1'b1, 8'hA1, 3'd3}) begin
      failures++;
      $display("FAIL fpp_pop got=%h exp=%h",
               {slaver_ready, master_valid, master_data, count}, {1'b1, 1'b1, 8'hA1, 3'd3});
    end
    tick();
    slaver_valid = 1'b0;
    #1;
    checks++;
    if ({slaver_ready, count} !== {1'b0, 3'd4} || {slaver_ready, master_valid, master_data, count} !== model_out()) begin
      failures++;
      $display("FAIL fpp_refill got rdy=%b cnt=%0d exp rdy=0 cnt=4", slaver_ready, count);
    end
    got.delete();
    drain();
    checks++;
    if (got.size() != 4 || got[0] !== 8'hA1 || got[3] !== 8'hB4) begin
      failures++;
      $display("FAIL fpp_order got=%p exp=a1 a2 a3 b4", got);
    end
  endtask

  task automatic test_reset_mid();
    master_ready = 1'b0; slaver_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slaver_data = 8'hC1 + DSIZE'(i);
      tick();
    end
    slaver_valid = 1'b0; rst = 1'b1;
    #1;
    checks++;
    if ({slaver_ready, master_valid, master_data, count} !== {1'b0, 1'b1, 8'hC1, 3'd3}) begin
      failures++;
      $display("FAIL rmid_pre got=%h exp=%h",
               {slaver_ready, master_valid, master_data, count}, {1'b0, 1'b1, 8'hC1, 3'd3});
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({slaver_ready, master_valid, master_data, count} !== {1'b1, 1'b0, 8'h00, 3'd0}) begin
      failures++;
      $display("FAIL rmid_post got=%h exp=%h",
               {slaver_ready, master_valid, master_data, count}, {1'b1, 1'b0, 8'h00, 3'd0});
    end
    got.delete();
    slaver_valid = 1'b1; slaver_data = 8'hA5; master_ready = 1'b1;
    tick();
    slaver_valid = 1'b0;
    #1;
    checks++;
    if ({master_valid, master_data, count} !== {1'b1, 8'hA5, 3'd1}) begin
      failures++;
      $display("FAIL rmid_first got=%h exp=%h", {master_valid, master_data, count}, {1'b1, 8'hA5, 3'd1});
    end
    drain();
    checks++;
    if (got.size() != 1 || got[0] !== 8'hA5) begin
      failures++;
      $display("FAIL rmid_order got=%p exp=a5", got);
    end
  endtask

  task automatic test_random();
    slaver_valid = 1'b0; last_push = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!(slaver_valid && !last_push)) begin
        slaver_valid = $urandom_range(0, 1) != 0;
        slaver_data  = DSIZE'($urandom);
      end
      master_ready = ($urandom_range(0, 3) != 0) ^ (c[6] == 1'b1 && c[5] == 1'b1);
      #1;
      checks++;
      if ({slaver_ready, master_valid, master_data, count} !== model_out()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c,
                 {slaver_ready, master_valid, master_data, count}, model_out());
      end
      tick();
      if (rst) last_push = 1'b1;
    end
    rst = 1'b0;
    drain();
  endtask

  task automatic test_bypass();
    for (int i = 0; i < 12; i++) begin
      b_slaver_valid = i[0];
      b_master_ready = i[1];
      b_slaver_data  = (i < 4) ? 8'h3C : DSIZE'($urandom);
      #1;
      checks++;
      if ({b_slaver_ready, b_master_valid, b_master_data, b_count} !==
          {b_master_ready, b_slaver_valid, b_slaver_data, 3'd0}) begin
        failures++;
        $display("FAIL bypass i=%0d got=%h exp=%h", i,
                 {b_slaver_ready, b_master_valid, b_master_data, b_count},
                 {b_master_ready, b_slaver_valid, b_slaver_data, 3'd0});
      end
      @(negedge clock);
    end
  endtask

  initial begin
    rst = 1'b1; slaver_valid = 1'b0; slaver_data = '0; master_ready = 1'b0;
    b_slaver_valid = 1'b0; b_slaver_data = '0; b_master_ready = 1'b0;
    test_reset();
    test_fill_full();
    test_stream_wrap();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_inf_b2a_fifo.md
Name: data_inf_b2a_fifo

Overview:
- Parametrised successor to the clocked-to-plain data_inf bridge: converts a `data_inf_c` slaver stream into a `data_inf` master stream.
- Adds selectable buffering instead of a pure wire-through.
- In buffered mode it is a first-word-fall-through FIFO.
  - This breaks the combinational ready path between consumer and producer.
  - It provides an occupancy count for upstream flow control.
- Sits at clock-domain-local interface boundaries where `data_inf_c` producers feed plain `data_inf` consumers.

Parameters:
- DSIZE, 8, payload width in bits.
- DEPTH, 4, FIFO entries. Power of two, ≥2. Ignored when MODE=0.
- MODE, 1:
  - 0 = combinational pass-through (legacy behaviour).
  - 1 = buffered FWFT FIFO.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- slaver_valid  in  1  upstream data valid (data_inf_c side).
- slaver_data  in  DSIZE  upstream payload.
- slaver_ready  out  1  upstream ready.
- master_valid  out  1  downstream data valid (data_inf side).
- master_data  out  DSIZE  downstream payload.
- master_ready  in  1  downstream ready.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Handshake rule, both sides: a transfer occurs on a rising edge where valid && ready are both high.
  - Valid, once asserted, may not be dropped by either producer until accepted. The FIFO honours this on master.
  - The bench asserts it on slaver.
- MODE=0:
  - slaver_ready = master_ready.
  - master_valid = slaver_valid.
  - master_data = slaver_data.
  - count tied to 0.
  - clock and rst unused. Zero latency.
- MODE=1, storage:
  - DEPTH x DSIZE register array.
  - wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits. The MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (address bits equal && wrap bits differ).
- MODE=1, push/pop:
  - push = slaver_valid && slaver_ready.
  - pop = master_valid && master_ready.
- MODE=1, outputs:
  - slaver_ready = !full && !rst.
  - master_valid = !empty.
  - master_data = mem[rd_ptr addr] when !empty, else all-zero.
  - All three are derived from registered state only. There is no combinational path from master_ready to slaver_ready or from slaver_valid to master_valid.
- Latency (MODE=1):
  - Word pushed at edge N appears with master_valid=1 in the cycle after edge N: 1-cycle latency, no empty bypass.
  - Sustained throughput is 1 word/cycle when neither side stalls.
- count:
  - Registered.
  - +1 on push-only, -1 on pop-only, unchanged on push&&pop or neither.
  - Always equals wr_ptr - rd_ptr (modulo 2·DEPTH).
- Full:
  - slaver_ready=0. No push can occur even if master pops in the same cycle.
  - slaver_ready reasserts the cycle after the first pop.
- Empty:
  - master_valid=0 and master_data=0. Pop impossible.
- Simultaneous push and pop (count between 1 and DEPTH-1):
  - Both pointers advance and count is held.
  - Order is preserved: the popped word is the oldest.
- Wrap-around:
  - Pointers roll from 2·DEPTH-1 to 0.
  - Data ordering and full/empty detection remain correct across any number of wraps.
- Reset:
  - While rst=1 at an edge: wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: master_valid=0, master_data=0, slaver_ready=0.
  - Memory contents are not cleared and are irrelevant because the FIFO is empty.
  - Reset mid-operation discards all stored words immediately. No partial transfer survives.
  - slaver_ready rises the first cycle rst is low.
- X-safety: no output may go X after reset, regardless of uninitialised memory.

Decomposition:
- Shared package `data_inf_pkg`:
  - enum `b2a_mode_e` {B2A_BYPASS=0, B2A_FIFO=1}.
  - function `ptr_w(depth)` = $clog2(depth)+1.
- Natural sub-module `data_inf_fwft_core`:
  - Contains pointers, memory, count, full/empty.
  - Generic valid/ready both sides, reusable by other bridges.
- Top-level `data_inf_b2a_fifo`:
  - Generate-selects bypass wires or the core by MODE.
  - Adapts the `data_inf_c` slaver / `data_inf` master interfaces onto it.

Test Plan (DSIZE=8, DEPTH=4 unless noted):
- Reset:
  - Stimulus: hold rst 3 cycles with slaver_valid=1.
  - Response: master_valid=0, master_data=0x00, count=0, slaver_ready=0 throughout. slaver_ready=1 first cycle after rst falls.
- Fill/full:
  - Stimulus: master_ready=0; push 0x11,0x22,0x33,0x44,0x55.
  - Response: count steps 1..4, slaver_ready=0 after 4th push, 0x55 held by producer. Then master_ready=1 pops 0x11,0x22,0x33,0x44,0x55 in order; count returns to 0.
- Streaming and wrap:
  - Stimulus: both sides always ready, push 0x00..0x13 (20 words).
  - Response: first master_valid one cycle after first push, then one word/cycle in order. count stays 1. Pointers wrap ≥2 times without loss.
- Simultaneous push/pop at full:
  - Stimulus: fill to 4, assert master_ready with slaver_valid=1.
  - Response: pop of oldest word, no push that cycle, count=3. Push accepted next cycle, count back to 4.
- Reset mid-operation:
  - Stimulus: with count=3, pulse rst 1 cycle.
  - Response: count=0, master_valid=0 next cycle. Old words never emitted. Subsequent push 0xA5 is the first word out.
- MODE=0 bypass:
  - Stimulus: toggle master_ready/slaver_valid with data 0x3C.
  - Response: outputs follow inputs in the same cycle, count=0 always.
